// File: rtl/ysyx_22050612_pkg.sv
// rtl/ysyx_22050612_pkg.sv - shared types and constants for the instruction fetch unit
package ysyx_22050612_pkg;

    localparam int XLEN = 64;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [31:0]     NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_t;

    // Instructions are 32-bit; any PC not on a word boundary is faulted without a bus access.
    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22050612_ifu_if.sv
// rtl/ysyx_22050612_ifu_if.sv - fetch unit memory port and EXU handoff bundle
interface ysyx_22050612_ifu_if;
    import ysyx_22050612_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            out_fault;
    logic [XLEN-1:0] exu_dnpc;
    logic [XLEN-1:0] fetch_cnt;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output out_valid, out_pc, out_inst, out_fault, fetch_cnt,
        input  out_ready, exu_dnpc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  out_valid, out_pc, out_inst, out_fault, fetch_cnt,
        output out_ready, exu_dnpc
    );

endinterface

// File: rtl/ysyx_22050612_pc_reg.sv
// rtl/ysyx_22050612_pc_reg.sv - architectural PC register with load enable
module ysyx_22050612_pc_reg
    import ysyx_22050612_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] d_i,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// rtl/ysyx_22050612_ifu.sv - single-outstanding instruction fetch unit feeding the EXU
module ysyx_22050612_ifu
    import ysyx_22050612_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0]     NOP_INST = ysyx_22050612_pkg::NOP_INST
) (
    input  logic                clk,
    input  logic                rst_n,
    ysyx_22050612_ifu_if.master bus
);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pc_load;
    logic            req_valid_q, req_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic            req_fire;
    logic            out_fire;

    // req_valid_q is only ever set while the FSM sits in REQ with an aligned PC.
    assign req_fire = req_valid_q && bus.imem_req_ready;
    assign out_fire = (state_q == ST_HOLD) && bus.out_ready;
    assign pc_load  = out_fire;
    assign pc_d     = pc_load ? bus.exu_dnpc : pc_q;

    ysyx_22050612_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (pc_load),
        .d_i    (bus.exu_dnpc),
        .q_o    (pc_q)
    );

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_REQ: begin
                if (pc_misaligned(pc_q)) begin
                    inst_d  = NOP_INST;
                    fault_d = 1'b1;
                    state_d = ST_HOLD;
                end else if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    inst_d  = bus.imem_rsp_err ? NOP_INST : bus.imem_rsp_data;
                    fault_d = bus.imem_rsp_err;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // Registered request valid keeps it low through reset and rising one cycle after release.
    assign req_valid_d = (state_d == ST_REQ) && !pc_misaligned(pc_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            req_valid_q <= 1'b0;
            inst_q      <= NOP_INST;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            inst_q      <= inst_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = (state_q == ST_HOLD);
    assign bus.out_pc         = pc_q;
    assign bus.out_inst       = inst_q;
    assign bus.out_fault      = fault_q;
    assign bus.fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// tb/tb_ysyx_22050612_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_22050612_ifu;
    import ysyx_22050612_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050612_ifu_if bus();

    ysyx_22050612_ifu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
        logic [63:0] cnt;
    } out_exp_t;

    out_exp_t    out_q[$];
    logic [63:0] req_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_cnt = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request", bus.imem_req_addr);
                end else begin
                    chk("sb_req_addr", bus.imem_req_addr, req_q.pop_front());
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pc %h expected no handoff", bus.out_pc);
                end else begin
                    out_exp_t e;
                    e = out_q.pop_front();
                    chk("sb_out_pc", bus.out_pc, e.pc);
                    chk("sb_out_inst", 64'(bus.out_inst), 64'(e.inst));
                    chk("sb_out_fault", 64'(bus.out_fault), 64'(e.fault));
                    chk("sb_fetch_cnt", bus.fetch_cnt, e.cnt);
                end
            end
        end
    end

    task automatic issue_req(input logic [63:0] pc, input int wait_exp, input int stall);
        int w = 0;
        while (bus.imem_req_valid !== 1'b1 && w < 8) begin
            step();
            w++;
        end
        chk("req_latency", 64'(w), 64'(wait_exp));
        req_q.push_back(pc);
        for (int i = 0; i < stall; i++) begin
            chk("req_stall_valid", 64'(bus.imem_req_valid), 64'd1);
            chk("req_stall_addr", bus.imem_req_addr, pc);
            step();
        end
        chk("req_addr", bus.imem_req_addr, pc);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        chk("wait_req_low", 64'(bus.imem_req_valid), 64'd0);
    endtask

    task automatic give_rsp(input logic [31:0] data, input logic err, input int stall);
        for (int i = 0; i < stall; i++) begin
            chk("wait_out_low", 64'(bus.out_valid), 64'd0);
            chk("wait_req_idle", 64'(bus.imem_req_valid), 64'd0);
            step();
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        bus.imem_rsp_err   = err;
        step();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        bus.imem_rsp_data  = $urandom;
    endtask

    task automatic hold(input logic [63:0] pc, input logic [31:0] inst, input logic fault,
                        input int stall, input logic [63:0] dnpc);
        out_q.push_back('{pc: pc, inst: inst, fault: fault, cnt: exp_cnt});
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < stall; i++) begin
            bus.exu_dnpc = {$urandom, $urandom};
            chk("stall_pc", bus.out_pc, pc);
            chk("stall_inst", 64'(bus.out_inst), 64'(inst));
            chk("stall_fault", 64'(bus.out_fault), 64'(fault));
            chk("stall_no_req", 64'(bus.imem_req_valid), 64'd0);
            step();
        end
        bus.out_ready = 1'b1;
        bus.exu_dnpc  = dnpc;
        step();
        bus.out_ready = 1'b0;
        bus.exu_dnpc  = {$urandom, $urandom};
        exp_cnt++;
        chk("fetch_cnt_after", bus.fetch_cnt, exp_cnt);
        chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic fetch(input logic [63:0] pc, input int wait_exp, input int req_stall,
                         input logic [31:0] data, input logic err, input int rsp_stall,
                         input int hold_stall, input logic [63:0] dnpc);
        issue_req(pc, wait_exp, req_stall);
        give_rsp(data, err, rsp_stall);
        hold(pc, err ? NOP_INST : data, err, hold_stall, dnpc);
    endtask

    task automatic fetch_misaligned(input logic [63:0] pc, input int hold_stall, input logic [63:0] dnpc);
        chk("mis_no_req", 64'(bus.imem_req_valid), 64'd0);
        chk("mis_out_low", 64'(bus.out_valid), 64'd0);
        step();
        chk("mis_fault", 64'(bus.out_fault), 64'd1);
        chk("mis_pc", bus.out_pc, pc);
        hold(pc, NOP_INST, 1'b1, hold_stall, dnpc);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
        chk({tag, "_req_addr"}, bus.imem_req_addr, RESET_PC_DEFAULT);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_pc"}, bus.out_pc, RESET_PC_DEFAULT);
        chk({tag, "_out_inst"}, 64'(bus.out_inst), 64'(NOP_INST));
        chk({tag, "_out_fault"}, 64'(bus.out_fault), 64'd0);
        chk({tag, "_fetch_cnt"}, bus.fetch_cnt, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.out_ready      = 1'b0;
        bus.exu_dnpc       = 64'h0;
        step();
        step();
        chk_reset_values("reset");
        rst_n = 1'b1;

        fetch(64'h8000_0000, 1, 0, 32'h0010_0093, 1'b0, 0, 0, 64'h8000_0004);
        fetch(64'h8000_0004, 0, 4, 32'h0020_0113, 1'b0, 2, 0, 64'h8000_0008);
        fetch(64'h8000_0008, 0, 0, 32'h0030_8193, 1'b0, 0, 5, 64'h8000_0100);
        fetch(64'h8000_0100, 0, 0, 32'hffff_ffff, 1'b1, 1, 0, 64'h8000_0002);
        fetch_misaligned(64'h8000_0002, 2, 64'h8000_0010);

        issue_req(64'h8000_0010, 0, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        step();
        step();
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hdead_beef;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("stray_out_valid", 64'(bus.out_valid), 64'd0);
        chk("stray_out_inst", 64'(bus.out_inst), 64'(NOP_INST));
        chk("stray_fetch_cnt", bus.fetch_cnt, 64'd0);
        exp_cnt = 64'd0;
        fetch(64'h8000_0000, 0, 0, 32'h0000_0073, 1'b0, 0, 0, 64'h8000_0004);

        step();
        chk("req_q_empty", 64'(req_q.size()), 64'd0);
        chk("out_q_empty", 64'(out_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
